// File: rtl/mem_resp_pkg.sv
// Shared types and protocol constants for the line-fill responder.
package mem_resp_pkg;

  localparam int LINE_W  = 128;
  localparam int ADDR_LO = 4;
  localparam int ADDR_HI = 31;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

  // A request with write asserted is a write, even if read is also high.
  function automatic op_e op_from_req(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/line_sram.sv
// Single-port synchronous line array; registered read data, one-cycle read latency.
module line_sram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_W     = 128
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Line-fill responder: backing store with programmable latency below one cache.
// Optional protocol checker enabled by defining MEM_PROTO_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; request latched on accept
// BUSY  | latency down-counter running; read issued when cnt==1
// RESP  | mem_ready pulse; write commits / read data presented
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_W     = mem_resp_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  op_e                     op_q, op_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;

  logic                    req;
  logic [DEPTH_LOG2-1:0]   idx_in;
  logic [DEPTH_LOG2-1:0]   sram_idx;
  logic                    sram_we;
  logic [LINE_W-1:0]       sram_rdata;
  logic                    unused_addr_hi;

  assign req            = mem_read | mem_write;
  assign idx_in         = mem_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = op_from_req(mem_write);
          idx_d   = idx_in;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (op_q == OP_RD) rdata_d = sram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
    op_q    <= op_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // In IDLE the live address feeds the array so LATENCY=1 can read in the accept cycle.
  assign sram_idx  = (state_q == IDLE) ? idx_in : idx_q;
  assign sram_we   = (state_q == RESP) && (op_q == OP_WR) && !rst;
  assign mem_ready = (state_q == RESP) && !rst;
  assign mem_rdata = (mem_ready && op_q == OP_RD) ? sram_rdata : rdata_q;

  line_sram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LINE_W    (LINE_W)
  ) u_line_sram (
    .clk  (clk),
    .we   (sram_we),
    .idx  (sram_idx),
    .wdata(wdata_q),
    .rdata(sram_rdata)
  );

`ifdef MEM_PROTO_CHECK_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pair_q, pair_d;
  logic              proto_err_q, proto_err_d;
  logic              in_txn, viol_addr, viol_op, viol_wdata, viol_both;

  always_comb begin
    addr_d = addr_q;
    pair_d = pair_q;
    if (state_q == IDLE && req) begin
      addr_d = mem_addr;
      pair_d = {mem_read, mem_write};
    end
    in_txn     = (state_q == BUSY) || (state_q == RESP);
    // A dropped request is tolerated; only a still-asserted but altered request is flagged.
    viol_addr  = in_txn && req && (mem_addr != addr_q);
    viol_op    = in_txn && req && ({mem_read, mem_write} != pair_q);
    viol_wdata = in_txn && (op_q == OP_WR) && mem_write && (mem_wdata != wdata_q);
    viol_both  = (state_q == IDLE) && mem_read && mem_write;
    proto_err_d = proto_err_q | viol_addr | viol_op | viol_wdata | viol_both;
  end

  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
    addr_q <= addr_d;
    pair_q <= pair_d;
  end

  assign proto_err = proto_err_q;

`ifndef SYNTHESIS
  int unsigned sim_cycle;
  always_ff @(posedge clk) begin
    sim_cycle <= sim_cycle + 1;
    if (!rst) begin
      if (viol_addr)  $display("mem_line_responder: cycle %0d protocol violation: address changed", sim_cycle);
      if (viol_op)    $display("mem_line_responder: cycle %0d protocol violation: opcode changed", sim_cycle);
      if (viol_wdata) $display("mem_line_responder: cycle %0d protocol violation: wdata changed", sim_cycle);
      if (viol_both)  $display("mem_line_responder: cycle %0d protocol violation: read and write both high", sim_cycle);
    end
  end
`endif
`else
  assign proto_err = 1'b0;
`endif

endmodule
